// File: rtl/comparator_2bit.sv
// ---------------------------------------------------------------------------
// comparator_2bit
//   Registered magnitude comparator for two WIDTH-bit operands. The operands
//   are sampled on a rising clk edge with in_valid high, and one-hot
//   eq/gt/sm flags come out one cycle later. There is no stall and no
//   backpressure, so back-to-back in_valid gives a new result every cycle.
//
// Parameters
//   WIDTH      operand width in bits, 1..16 (default 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high (has priority over in_valid)
//   a, b       operands (WIDTH bits)
//   in_valid   sample a/b on this edge
//   eq         registered a == b
//   gt         registered a >  b
//   sm         registered a <  b
//   out_valid  flags belong to the pair sampled on the previous edge
//
// Configuration
//   COMPARATOR_SIGNED_EN  defined: a/b are two's-complement for gt/sm.
//                         undefined (default): unsigned compare.
//                         eq is the same in both modes.
// ---------------------------------------------------------------------------
module comparator_2bit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             eq,
    output logic             gt,
    output logic             sm,
    output logic             out_valid
);

    logic cmp_eq;
    logic cmp_gt;
    logic cmp_sm;

    // Only the gt/sm decision depends on signedness. eq is a plain bitwise
    // match.
    always_comb begin
        cmp_eq = (a == b);
`ifdef COMPARATOR_SIGNED_EN
        cmp_gt = ($signed(a) > $signed(b));
        cmp_sm = ($signed(a) < $signed(b));
`else
        cmp_gt = (a > b);
        cmp_sm = (a < b);
`endif
    end

    // The flags load only when in_valid is high. This holds the last result
    // and stops don't-care (possibly X) operands from reaching the outputs
    // while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            eq        <= 1'b0;
            gt        <= 1'b0;
            sm        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                eq <= cmp_eq;
                gt <= cmp_gt;
                sm <= cmp_sm;
            end
        end
    end

endmodule

// File: tb/tb_comparator_2bit.sv
module tb_comparator_2bit;

    localparam int W = 2;
`ifdef COMPARATOR_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         eq, gt, sm, out_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: the expected flags after the most recent edge.
    logic m_eq = 1'b0, m_gt = 1'b0, m_sm = 1'b0, m_valid = 1'b0;

    comparator_2bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .eq(eq), .gt(gt), .sm(sm), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         iv;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         x_eq;
        logic         x_gt;
        logic         x_sm;
        logic         x_valid;
    } vec_t;

    function automatic int to_num(input logic [W-1:0] x);
        int v;
        v = int'(x);
        if (SGN && x[W-1]) v = v - (1 << W);
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, update the reference model, and compare after the edge.
    task automatic step(input logic r, input logic iv,
                        input logic [W-1:0] va, input logic [W-1:0] vb);
        int na, nb;
        rst = r; in_valid = iv; a = va; b = vb;
        @(posedge clk);
        if (r) begin
            m_eq = 0; m_gt = 0; m_sm = 0; m_valid = 0;
        end else if (iv) begin
            na = to_num(va); nb = to_num(vb);
            m_eq = (na == nb); m_gt = (na > nb); m_sm = (na < nb); m_valid = 1;
        end else begin
            m_valid = 0;
        end
        #1;
        chk("model_eq", eq, m_eq);
        chk("model_gt", gt, m_gt);
        chk("model_sm", sm, m_sm);
        chk("model_out_valid", out_valid, m_valid);
        if (out_valid === 1'b1)
            chk("one_hot", ((eq + gt + sm) == 2'd1), 1'b1);
    endtask

    vec_t tbl[$];

    initial begin
        // Directed table. In the signed build 2 = -2 and 3 = -1.
        tbl.push_back('{1, 0, 2'd0, 2'd0, 0, 0, 0, 0});          // reset cycle 1
        tbl.push_back('{1, 1, 2'd1, 2'd2, 0, 0, 0, 0});          // reset cycle 2 beats in_valid
        tbl.push_back('{0, 0, 2'd3, 2'd0, 0, 0, 0, 0});          // idle: unchanged
        tbl.push_back('{0, 1, 2'd2, 2'd2, 1, 0, 0, 1});          // eq
        tbl.push_back('{0, 1, 2'd3, 2'd1, 0, !SGN, SGN, 1});     // 3>1 / -1<1
        tbl.push_back('{0, 1, 2'd0, 2'd3, 0, SGN, !SGN, 1});     // 0<3 / 0>-1
        tbl.push_back('{0, 1, 2'd1, 2'd2, 0, SGN, !SGN, 1});     // 1<2 / 1>-2
        tbl.push_back('{0, 0, 2'd3, 2'd0, 0, SGN, !SGN, 0});     // hold, out_valid drops
        tbl.push_back('{0, 1, 2'd3, 2'd0, 0, 1, 0, 1});          // 3>0 / -1<0 is sm in signed
        tbl.push_back('{1, 1, 2'd3, 2'd0, 0, 0, 0, 0});          // reset mid-stream
        tbl.push_back('{0, 1, 2'd1, 2'd2, 0, SGN, !SGN, 1});
        // The signed row above with a=3,b=0 expects gt=1, which is wrong for signed.
        // Fix it here.
        if (SGN) begin
            tbl[8].x_gt = 0;
            tbl[8].x_sm = 1;
        end

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].va, tbl[i].vb);
            chk($sformatf("tbl%0d_eq", i), eq, tbl[i].x_eq);
            chk($sformatf("tbl%0d_gt", i), gt, tbl[i].x_gt);
            chk($sformatf("tbl%0d_sm", i), sm, tbl[i].x_sm);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].x_valid);
        end

        // Exhaustive back-to-back sweep of all operand pairs.
        for (int i = 0; i < (1 << W); i++)
            for (int j = 0; j < (1 << W); j++)
                step(1'b0, 1'b1, W'(i), W'(j));

        // Randomised traffic with occasional reset and idle cycles.
        for (int k = 0; k < 400; k++) begin
            logic r, iv;
            r  = ($urandom_range(0, 19) == 0);
            iv = $urandom_range(0, 2) != 0;
            step(r, iv, W'($urandom), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
